piso_shift_tx: RTL

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx_if.sv | 33 +++
 rtl/piso_shift_tx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// The master drives the load/strobe side and the slave serialises.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             i_load_valid;
    logic [WIDTH-1:0] i_load_data;
    logic             o_load_ready;
    logic             i_shift_en;
    logic             o_data;
    logic             o_sof;
    logic             o_busy;

    modport master (
        output i_load_valid,
        output i_load_data,
        output i_shift_en,
        input  o_load_ready,
        input  o_data,
        input  o_sof,
        input  o_busy
    );

    modport slave (
        input  i_load_valid,
        input  i_load_data,
        input  i_shift_en,
        output o_load_ready,
        output o_data,
        output o_sof,
        output o_busy
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer so that
// consecutive words leave the shift register with no idle bit between them.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic           CLK,
    input  logic           RST,
    piso_shift_tx_if.slave bus
);

    localparam int unsigned       CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_valid_q, buf_valid_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             data_q;
    logic             sof_q;
    logic             busy_q;
    logic             ready_q;

    logic             handshake;
    logic             drain;
    logic [WIDTH-1:0] sreg_shifted;

    function automatic logic out_bit(input logic [WIDTH-1:0] r);
        return LSB_FIRST ? r[0] : r[WIDTH-1];
    endfunction

    // Shift toward whichever end drives the serial output.
    assign sreg_shifted = LSB_FIRST ? {1'b0, sreg_q[WIDTH-1:1]}
                                    : {sreg_q[WIDTH-2:0], 1'b0};

    always_comb begin
        handshake   = bus.i_load_valid & ready_q;
        drain       = 1'b0;
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: begin
                if (buf_valid_q) begin
                    drain   = 1'b1;
                    sreg_d  = buf_q;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (bus.i_shift_en) begin
                    if (cnt_q == CntLast) begin
                        if (buf_valid_q) begin
                            drain  = 1'b1;
                            sreg_d = buf_q;
                            cnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Ready is low whenever the buffer is full, so drain and handshake
        // never coincide.
        if (drain) begin
            buf_valid_d = 1'b0;
        end
        if (handshake) begin
            buf_d       = bus.i_load_data;
            buf_valid_d = 1'b1;
        end
    end

    // Outputs are registered from next-state so they track the current state
    // without any combinational path from the inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            data_q      <= 1'b0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            data_q      <= (state_d == StShift) ? out_bit(sreg_d) : 1'b0;
            sof_q       <= (state_d == StShift) && (cnt_d == '0);
            busy_q      <= (state_d == StShift);
            ready_q     <= ~buf_valid_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_sof        = sof_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_load_ready = ready_q;

endmodule
